// File: rtl/seg7_pkg.sv
// Shared glyph table, scan state encoding and sizing helper for the 7-segment scan controller.
// Glyphs are active-low, packed a..g as bit 6..bit 0.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_GHOST = 1'b1
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Digit-write port plus display pins of the scan controller.
// master = control/board side, slave = the scan controller.
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int AW = $clog2(NUM_DIGITS);

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [3:0]            wr_data;
  logic                  led_a;
  logic                  led_b;
  logic                  led_c;
  logic                  led_d;
  logic                  led_e;
  logic                  led_f;
  logic                  led_g;
  logic [NUM_DIGITS-1:0] dig_sel;
  logic                  frame_tick;

  modport master (
    output wr_en, wr_addr, wr_data,
    input  led_a, led_b, led_c, led_d, led_e, led_f, led_g, dig_sel, frame_tick
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    output led_a, led_b, led_c, led_d, led_e, led_f, led_g, dig_sel, frame_tick
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational hex-digit to active-low 7-segment decoder; values 10..15 or blank_i give all-off.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] val_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (val_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: show window per digit, ghost-blank gap, registered outputs.
// Define SEG7_LZB_EN to blank leading zeros (digit 0 is never suppressed).
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SHOW_CYC   = 50000,
  parameter int GHOST_CYC  = 500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  seg7_scan_ctrl_if.slave  bus
);

  localparam int AW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(max_int(SHOW_CYC, GHOST_CYC));

  localparam logic [AW:0]   ND         = (AW+1)'(NUM_DIGITS);
  localparam logic [AW-1:0] IDX_LAST   = AW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYC - 1);
  localparam logic [CW-1:0] GHOST_LAST = CW'(GHOST_CYC - 1);

  logic [3:0]            digit_q [NUM_DIGITS];

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic                  wrap_d;

  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic [6:0]            seg_q, seg_d;
  logic                  tick_q;

  logic                  show_d;
  logic [NUM_DIGITS-1:0] lz_blank;

  // Writes land regardless of en or scan state; out-of-range addresses drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_q[i] <= 4'hF;
      end
    end else if (bus.wr_en && ({1'b0, bus.wr_addr} < ND)) begin
      digit_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    if (en) begin
      unique case (state_q)
        ST_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = ST_GHOST;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_GHOST: begin
          if (cnt_q == GHOST_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d  = '0;
              wrap_d = 1'b1;
            end else begin
              idx_d = idx_q + AW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_GHOST;
          cnt_d   = '0;
        end
      endcase
    end
  end

`ifdef SEG7_LZB_EN
  logic lead_zero;

  // Walk down from the most significant digit; blank while every digit so far is zero.
  always_comb begin
    lead_zero = 1'b1;
    lz_blank  = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lead_zero   = lead_zero && (digit_q[i] == 4'd0);
      lz_blank[i] = lead_zero;
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Outputs are computed from the next state so select and glyph flip on the same edge.
  assign show_d = en && (state_d == ST_SHOW);
  assign dig_d  = show_d ? ~(NUM_DIGITS'(1) << idx_d) : '1;

  seg7_decode u_decode (
    .val_i   (digit_q[idx_d]),
    .blank_i (!show_d || lz_blank[idx_d]),
    .seg_o   (seg_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_GHOST;
      cnt_q   <= '0;
      idx_q   <= IDX_LAST;
      dig_q   <= '1;
      seg_q   <= SEG_BLANK;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      seg_q   <= seg_d;
      tick_q  <= wrap_d;
    end
  end

  assign bus.led_a      = seg_q[6];
  assign bus.led_b      = seg_q[5];
  assign bus.led_c      = seg_q[4];
  assign bus.led_d      = seg_q[3];
  assign bus.led_e      = seg_q[2];
  assign bus.led_f      = seg_q[1];
  assign bus.led_g      = seg_q[0];
  assign bus.dig_sel    = dig_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: glyph table, scripted corner cases and random traffic
// checked every cycle against a frame-position reference model.
module tb_seg7_scan_ctrl;

  localparam int N = 4;
  localparam int S = 8;
  localparam int G = 2;
  localparam int P = S + G;

  logic clk = 1'b0;
  logic rst;
  logic en;

  always #5 clk = ~clk;

  seg7_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

  seg7_scan_ctrl #(
    .NUM_DIGITS (N),
    .SHOW_CYC   (S),
    .GHOST_CYC  (G)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus)
  );

  logic [6:0] sa;
  assign sa = {bus.led_a, bus.led_b, bus.led_c, bus.led_d, bus.led_e, bus.led_f, bus.led_g};

  typedef struct {
    logic [3:0] val;
    logic [6:0] seg;
  } gvec_t;

  gvec_t gtab [16];

  int vecs   = 0;
  int errs   = 0;
  int cyc_no = 0;

  // Reference model: scan position is a pure count of enabled cycles since reset.
  int         m_t;
  int         m_d;
  int         m_w;
  logic [3:0] m_reg [N];
  logic [N-1:0] e_dig;
  logic [6:0]   e_seg;
  logic         e_tick;

  function automatic logic [6:0] ref_glyph(input logic [3:0] v);
    case (v)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic ref_blank(input int d);
`ifdef SEG7_LZB_EN
    int h = 0;
    for (int j = 0; j < N; j++) if (m_reg[j] != 4'd0) h = j;
    return d > h;
`else
    return (d < 0);
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc_no, act, exp);
    end
  endtask

  task automatic cyc();
    int p;
    @(posedge clk);
    cyc_no++;
    m_d    = -1;
    e_dig  = '1;
    e_seg  = 7'h7F;
    e_tick = 1'b0;
    if (rst) begin
      m_t = 0;
      for (int i = 0; i < N; i++) m_reg[i] = 4'hF;
    end else begin
      if (en) begin
        m_t++;
        p = m_t + (N - 1) * P + S;
        if ((p % P) < S) begin
          m_d    = (p / P) % N;
          m_w    = p % P;
          e_dig  = ~(N'(1) << m_d);
          e_seg  = ref_blank(m_d) ? 7'h7F : ref_glyph(m_reg[m_d]);
          e_tick = (m_d == 0) && (m_w == 0);
        end
      end
      if (bus.wr_en) m_reg[bus.wr_addr] = bus.wr_data;
    end
    #1;
    chk("scan", {20'd0, bus.dig_sel, sa, bus.frame_tick}, {20'd0, e_dig, e_seg, e_tick});
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] v);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = v;
    cyc();
    bus.wr_en   = 1'b0;
  endtask

  task automatic show_check(input int d, input logic [6:0] exp, input string nm);
    int k = 0;
    en = 1'b1;
    do begin
      cyc();
      k++;
    end while (!(m_d == d && m_w == 0) && k < 100);
    if (k >= 100) begin
      vecs++;
      errs++;
      $display("FAIL %s: digit %0d never selected within 100 cycles", nm, d);
    end else begin
      chk(nm, {21'd0, bus.dig_sel, sa}, {21'd0, ~(N'(1) << d), exp});
    end
  endtask

  initial begin
    int last_tick;
    int lit;
    int k;

    for (int i = 0; i < 16; i++) begin
      gtab[i].val = 4'(i);
      gtab[i].seg = 7'b1111111;
    end
    gtab[0].seg = 7'b0000001;  gtab[1].seg = 7'b1001111;
    gtab[2].seg = 7'b0010010;  gtab[3].seg = 7'b0000110;
    gtab[4].seg = 7'b1001100;  gtab[5].seg = 7'b0100100;
    gtab[6].seg = 7'b0100000;  gtab[7].seg = 7'b0001111;
    gtab[8].seg = 7'b0000000;  gtab[9].seg = 7'b0000100;

    rst         = 1'b1;
    en          = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;

    // Reset state, then idle with en low.
    cyc();
    cyc();
    chk("reset_out", {20'd0, bus.dig_sel, sa, bus.frame_tick}, {20'd0, 4'b1111, 7'b1111111, 1'b0});
    rst = 1'b0;
    repeat (3) cyc();

    // Free scan with blank registers; frame_tick spacing.
    en = 1'b1;
    last_tick = -1;
    repeat (100) begin
      cyc();
      if (bus.frame_tick) begin
        if (last_tick >= 0) chk("tick_period", cyc_no - last_tick, 40);
        last_tick = cyc_no;
      end
    end

    for (int i = 0; i < 16; i++) begin
      wr(2'd0, gtab[i].val);
      show_check(0, gtab[i].seg, "glyph_table");
    end

    wr(2'd3, 4'd1);
    wr(2'd2, 4'd2);
    wr(2'd1, 4'd3);
    wr(2'd0, 4'd4);
    show_check(0, 7'b1001100, "digit0_val4");
    show_check(1, 7'b0000110, "digit1_val3");
    show_check(2, 7'b0010010, "digit2_val2");
    show_check(3, 7'b1001111, "digit3_val1");

    // Overwrite the digit on display: one-cycle latency, select untouched.
    show_check(0, 7'b1001100, "pre_write");
    cyc();
    bus.wr_en   = 1'b1;
    bus.wr_addr = 2'd0;
    bus.wr_data = 4'd8;
    cyc();
    bus.wr_en = 1'b0;
    chk("wr_edge_old", {21'd0, bus.dig_sel, sa}, {21'd0, 4'b1110, 7'b1001100});
    cyc();
    chk("wr_next_new", {21'd0, bus.dig_sel, sa}, {21'd0, 4'b1110, 7'b0000000});

    // Pause mid-show; lit time of the digit must still total the full window.
    show_check(1, 7'b0000110, "pre_pause");
    lit = 1;
    repeat (2) begin cyc(); if (bus.dig_sel == 4'b1101) lit++; end
    en = 1'b0;
    repeat (5) begin cyc(); if (bus.dig_sel == 4'b1101) lit++; end
    en = 1'b1;
    repeat (12) begin cyc(); if (bus.dig_sel == 4'b1101) lit++; end
    chk("pause_lit_total", lit, S);

    repeat (800) begin
      en          = ($urandom_range(0, 9) != 0);
      rst         = ($urandom_range(0, 199) == 0);
      bus.wr_en   = ($urandom_range(0, 3) == 0);
      bus.wr_addr = 2'($urandom_range(0, 3));
      bus.wr_data = 4'($urandom_range(0, 15));
      cyc();
    end
    rst       = 1'b0;
    bus.wr_en = 1'b0;
    en        = 1'b1;

`ifdef SEG7_LZB_EN
    for (int i = 0; i < N; i++) wr(2'(i), 4'd0);
    show_check(1, 7'b1111111, "lzb_zero_d1");
    show_check(2, 7'b1111111, "lzb_zero_d2");
    show_check(3, 7'b1111111, "lzb_zero_d3");
    show_check(0, 7'b0000001, "lzb_zero_d0");
    wr(2'd2, 4'd5);
    show_check(3, 7'b1111111, "lzb_05_d3");
    show_check(0, 7'b0000001, "lzb_05_d0");
    show_check(1, 7'b0000001, "lzb_05_d1");
    show_check(2, 7'b0100100, "lzb_05_d2");
`endif

    // Reset while digit 2 is lit; first digit 0 appears after two ghost cycles.
    k = 0;
    do begin cyc(); k++; end while (m_d != 2 && k < 100);
    if (k >= 100) begin
      vecs++;
      errs++;
      $display("FAIL rst_wait: digit 2 never selected within 100 cycles");
    end
    rst = 1'b1;
    cyc();
    chk("rst_midscan", {20'd0, bus.dig_sel, sa, bus.frame_tick}, {20'd0, 4'b1111, 7'b1111111, 1'b0});
    rst = 1'b0;
    cyc();
    chk("rst_ghost", {20'd0, bus.dig_sel, sa, bus.frame_tick}, {20'd0, 4'b1111, 7'b1111111, 1'b0});
    cyc();
    chk("rst_first_d0", {20'd0, bus.dig_sel, sa, bus.frame_tick}, {20'd0, 4'b1110, 7'b1111111, 1'b1});
    repeat (45) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
